// File: rtl/fp_normalize_shifter.sv
// ---------------------------------------------------------------------------
// fp_normalize_shifter : post-add normaliser, one left shift per clock.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp_normalize_shifter #(
  parameter int MANT_W = 25,
  parameter int EXP_W  = 8,
  parameter int CNT_W  = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [MANT_W-1:0] mant_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              busy,
  output logic              done,
  output logic [MANT_W-1:0] mant_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [CNT_W-1:0]  shift_cnt,
  output logic              zero,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [EXP_W-1:0] C_EXP_ONES = '1;
  localparam logic [EXP_W-1:0] C_EXP_ONE  = EXP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [EXP_W-1:0]  w_exp_inc;

  // Carry increment saturates so the exponent never wraps past infinity.
  assign w_exp_inc = (exp_q == C_EXP_ONES) ? exp_q : exp_q + C_EXP_ONE;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mant_d  = mant_in;
          exp_d   = exp_in;
          cnt_d   = '0;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (mant_q == '0) begin
          exp_d   = '0;
          zero_d  = 1'b1;
          state_d = S_DONE;
        end else if (mant_q[MANT_W-1]) begin
          exp_d   = w_exp_inc;
          state_d = S_DONE;
          if (w_exp_inc == C_EXP_ONES) begin
            ovf_d  = 1'b1;
            mant_d = '0;
          end else begin
            mant_d = mant_q >> 1;
          end
        end else if (mant_q[MANT_W-2]) begin
          state_d = S_DONE;
        end else if (exp_q <= C_EXP_ONE) begin
          unf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - C_EXP_ONE;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mant_out  = mant_q;
  assign exp_out   = exp_q;
  assign shift_cnt = cnt_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_normalize_shifter.sv
// ---------------------------------------------------------------------------
// tb_fp_normalize_shifter : randomized self-checking bench for fp_normalize_shifter.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fp_normalize_shifter;

  localparam int MW = 25;
  localparam int EW = 8;
  localparam int CW = 5;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          start = 1'b0;
  logic [MW-1:0] mant_in = '0;
  logic [EW-1:0] exp_in = '0;
  logic          busy, done, zero, overflow, underflow;
  logic [MW-1:0] mant_out;
  logic [EW-1:0] exp_out;
  logic [CW-1:0] shift_cnt;

  int checks = 0;
  int errors = 0;

  fp_normalize_shifter #(.MANT_W(MW), .EXP_W(EW), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .mant_in(mant_in), .exp_in(exp_in),
    .busy(busy), .done(done), .mant_out(mant_out), .exp_out(exp_out),
    .shift_cnt(shift_cnt), .zero(zero), .overflow(overflow), .underflow(underflow)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: find how far the leading one sits below the hidden bit and
  // limit the shift by how far the exponent may fall before reaching 1.
  task automatic model(input logic [MW-1:0] m, input logic [EW-1:0] e,
                       output logic [MW-1:0] mo, output logic [EW-1:0] eo,
                       output int k, output bit z, output bit ov, output bit un);
    int msb, need, avail, ei;
    mo = m; eo = e; k = 0; z = 0; ov = 0; un = 0;
    if (m == 0) begin
      eo = '0;
      z  = 1;
    end else if (m[MW-1]) begin
      ei = int'(e) + 1;
      if (ei >= (1 << EW) - 1) begin
        eo = '1; ov = 1; mo = '0;
      end else begin
        eo = EW'(ei); mo = m / 2;
      end
    end else begin
      msb = 0;
      for (int i = 0; i < MW; i++) if (m[i]) msb = i;
      need  = (MW - 2) - msb;
      avail = (e > 1) ? int'(e) - 1 : 0;
      k     = (need <= avail) ? need : avail;
      un    = (need > avail);
      mo    = m * (1 << k);
      eo    = EW'(int'(e) - k);
    end
  endtask

  // Waits for done, then checks latency and the result. lat_add < 0 skips the
  // latency check; pulse_chk also verifies done drops and results hold.
  task automatic collect(input string tag, input logic [MW-1:0] m, input logic [EW-1:0] e,
                         input int lat_add, input bit pulse_chk);
    logic [MW-1:0] mo;
    logic [EW-1:0] eo;
    int k, n;
    bit z, ov, un;
    model(m, e, mo, eo, k, z, ov, un);
    n = 0;
    do begin
      @(posedge Clk); #1;
      n++;
      if (busy && !done) start = 1'b0;
    end while (!done && n < 60);
    start = 1'b0;
    if (!done) begin
      check({tag, ".timeout"}, 32'(done), 32'd1);
      return;
    end
    if (lat_add >= 0) check({tag, ".latency"}, 32'(n), 32'(k + 2 + lat_add));
    check({tag, ".busy"}, 32'(busy), 32'd1);
    check({tag, ".mant"}, 32'(mant_out), 32'(mo));
    check({tag, ".exp"}, 32'(exp_out), 32'(eo));
    check({tag, ".cnt"}, 32'(shift_cnt), 32'(k));
    check({tag, ".flags"}, {29'd0, zero, overflow, underflow}, {29'd0, z, ov, un});
    if (pulse_chk) begin
      @(posedge Clk); #1;
      check({tag, ".pulse"}, {30'd0, done, busy}, 32'd0);
      check({tag, ".hold"}, 32'(mant_out), 32'(mo));
    end
  endtask

  task automatic issue(input logic [MW-1:0] m, input logic [EW-1:0] e);
    mant_in = m;
    exp_in  = e;
    start   = 1'b1;
  endtask

  logic [MW-1:0] d_m [10] = '{25'h0800000, 25'h1800000, 25'h0000001, 25'h0000100, 25'h0000000,
                               25'h1000000, 25'h1FFFFFF, 25'h0000004, 25'h0000003, 25'h0400000};
  logic [EW-1:0] d_e [10] = '{8'h80, 8'h80, 8'h80, 8'h03, 8'h55,
                               8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};

  initial begin : main
    int dn;
    logic [MW-1:0] rm;
    logic [EW-1:0] re;
    repeat (3) @(posedge Clk);
    #1;
    check("reset.ctl", {30'd0, busy, done}, 32'd0);
    check("reset.mant", 32'(mant_out), 32'd0);
    check("reset.rest", {20'd0, exp_out, shift_cnt, zero, overflow, underflow}, 32'd0);
    Reset = 1'b1;
    @(posedge Clk); #1;

    for (int i = 0; i < 10; i++) begin
      issue(d_m[i], d_e[i]);
      collect($sformatf("dir%0d", i), d_m[i], d_e[i], 0, 1'b1);
    end

    // Abort in the fifth NORM cycle of a long normalisation.
    issue(25'h0000001, 8'h80);
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    check("abort.ctl", {30'd0, busy, done}, 32'd0);
    check("abort.mant", 32'(mant_out), 32'd0);
    check("abort.rest", {20'd0, exp_out, shift_cnt, zero, overflow, underflow}, 32'd0);
    Reset = 1'b1;
    dn = 0;
    repeat (30) begin
      @(posedge Clk); #1;
      if (done) dn++;
    end
    check("abort.nodone", 32'(dn), 32'd0);

    // start while busy must be ignored.
    issue(25'h0000100, 8'h80);
    @(posedge Clk); #1;
    start = 1'b0;
    @(posedge Clk); #1;
    issue(25'h1800000, 8'h10);
    @(posedge Clk); #1;
    start = 1'b0;
    mant_in = '0;
    collect("busyign", 25'h0000100, 8'h80, -1, 1'b1);

    // Back-to-back: second start raised on the done cycle of the first.
    issue(25'h0800000, 8'h40);
    collect("b2b.a", 25'h0800000, 8'h40, 0, 1'b0);
    issue(25'h0000010, 8'h40);
    collect("b2b.b", 25'h0000010, 8'h40, 1, 1'b1);

    for (int i = 0; i < 200; i++) begin
      rm = MW'($urandom) >> $urandom_range(0, MW);
      case ($urandom_range(0, 3))
        0:       re = EW'($urandom_range(0, 4));
        1:       re = EW'($urandom_range(250, 255));
        default: re = EW'($urandom);
      endcase
      issue(rm, re);
      collect($sformatf("rnd%0d", i), rm, re, 0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
